score_mult_scheduler: RTL and testbench
=======================================

Name: score_mult_scheduler

Overview:
- Owns the single shared shift-add multiplier used for score computation at end of game.
- Serves two requesters: the time-score path and the discovered-pairs-score path.
- Each product is the requester's 6-bit operand times a fixed score coefficient.
- Arbitrates round-robin, runs one multiply at a time, and holds each requester's result in its own register until overwritten or flushed.

Parameters:
OP_WIDTH, 6, operand width (multiplier value from score logic, 0..63)
COEF, 100, constant score coefficient applied to every operand
COEF_WIDTH, 7, width of COEF
RES_WIDTH, 13, result width; must be >= OP_WIDTH+COEF_WIDTH

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear (new game): aborts current op, zeroes both results
req_time  in  1  time-path request, level; held until done_time
op_time  in  OP_WIDTH  time-path operand, sampled at grant
req_pairs  in  1  pairs-path request, level; held until done_pairs
op_pairs  in  OP_WIDTH  pairs-path operand, sampled at grant
gnt_time  out  1  1-cycle pulse: op_time captured
gnt_pairs  out  1  1-cycle pulse: op_pairs captured
done_time  out  1  1-cycle pulse: mult_time_result updated
done_pairs  out  1  1-cycle pulse: mult_discovered_pairs_result updated
mult_time_result  out  RES_WIDTH  op_time*COEF, held
mult_discovered_pairs_result  out  RES_WIDTH  op_pairs*COEF, held
busy  out  1  high in MUL and DONE states

Behaviour:
- Reset (rst_n low, any time, async): state IDLE; all outputs 0; accumulator, bit counter and captured operand cleared; priority pointer set to time path.
- States are IDLE, MUL and DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, the priority pointer picks the winner.
  - At the clock edge: capture the winner's operand, clear the accumulator, set bit counter to 0, record the owner, go to MUL.
  - The owner's gnt is asserted (registered) in the first MUL cycle.
- MUL:
  - Runs exactly OP_WIDTH cycles, LSB first.
  - In cycle i: if operand bit i is set, acc <= acc + (COEF << i).
  - After bit OP_WIDTH-1, go to DONE.
  - acc is RES_WIDTH wide; with defaults, 63*100 = 6300 < 8192, so no overflow.
- DONE (one cycle):
  - The owner's result register holds acc and the owner's done is high this cycle.
  - The other result register is unchanged.
  - The priority pointer flips to the non-owner.
  - Next state is IDLE.
- Latency: req high in IDLE cycle 0 gives gnt in cycle 1 and done plus valid result in cycle OP_WIDTH+1 (7 with defaults). The earliest next grant is cycle OP_WIDTH+3.
- Requesters drop req in the done cycle. A req still high when IDLE is re-entered is treated as a new request.
- req deasserted during MUL: the operation still completes and done still pulses; there is no abort.
- Operand changes after grant are ignored.
- Operand 0 still takes the full latency and yields result 0 with a done pulse.
- flush:
  - Takes priority over everything. The next state is IDLE.
  - Both result registers go to 0; gnt and done are 0 the next cycle.
  - The priority pointer resets to the time path.
  - An in-flight op is discarded with no done pulse.
  - flush high in IDLE blocks grants.
- gnt and done are never asserted for both paths in the same cycle.
- busy is low only in IDLE.

Test Plan:
- Single request: op_time=17, req_time high at cycle 0 -> gnt_time at cycle 1, done_time at cycle 7, mult_time_result=1700; mult_discovered_pairs_result stays 0.
- Simultaneous requests after reset: op_time=32, op_pairs=5 -> time served first (done_time cycle 7, 3200), then pairs (gnt_pairs cycle 9, done_pairs cycle 15, 500). A second simultaneous round is served pairs first.
- Operand extremes: op_pairs=0 -> done_pairs after 7 cycles with result 0. op_time=63 -> 6300; no overflow, previous pairs result retained.
- Request withdrawal and operand change: req_time dropped at cycle 3, op_time changed to 1 at cycle 2 (granted with 40) -> done_time still at cycle 7 with 4000.
- flush in cycle 4 of a MUL (op_pairs=9) -> no done_pairs, both results 0, busy 0 next cycle. A subsequent simultaneous request grants the time path first.
- Async reset: rst_n pulsed low mid-MUL, between clock edges -> all outputs 0 immediately. After release, a new req_pairs with op=3 -> 300 at cycle 7.

Source files
------------

// File: rtl/score_mult_scheduler.sv
// Shared shift-add multiplier for end-of-game scoring. Two requesters (time, discovered pairs)
// are served round-robin. Each product is operand*COEF and lands in that requester's own register.
module score_mult_scheduler #(
  parameter int unsigned OP_WIDTH   = 6,
  parameter int unsigned COEF       = 100,
  parameter int unsigned COEF_WIDTH = 7,
  parameter int unsigned RES_WIDTH  = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_time,
  input  logic [OP_WIDTH-1:0]  op_time,
  input  logic                 req_pairs,
  input  logic [OP_WIDTH-1:0]  op_pairs,
  output logic                 gnt_time,
  output logic                 gnt_pairs,
  output logic                 done_time,
  output logic                 done_pairs,
  output logic [RES_WIDTH-1:0] mult_time_result,
  output logic [RES_WIDTH-1:0] mult_discovered_pairs_result,
  output logic                 busy
);

  localparam int unsigned CntW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
  localparam logic [RES_WIDTH-1:0] CoefExt = RES_WIDTH'(COEF_WIDTH'(COEF));
  localparam logic [CntW-1:0] LastBit = CntW'(OP_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e               r_state, w_state_next;
  logic [RES_WIDTH-1:0] r_acc, w_acc_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic [OP_WIDTH-1:0]  r_op, w_op_next;
  logic                 r_owner, w_owner_next;  // 0: time path, 1: pairs path
  logic                 r_ptr, w_ptr_next;      // favoured path on a tie
  logic                 r_gnt_time, w_gnt_time_next;
  logic                 r_gnt_pairs, w_gnt_pairs_next;
  logic                 r_done_time, w_done_time_next;
  logic                 r_done_pairs, w_done_pairs_next;
  logic [RES_WIDTH-1:0] r_res_time, w_res_time_next;
  logic [RES_WIDTH-1:0] r_res_pairs, w_res_pairs_next;
  logic                 w_pick_pairs;
  logic [RES_WIDTH-1:0] w_sum;

  assign w_pick_pairs = req_pairs & (~req_time | r_ptr);
  assign w_sum        = r_acc + (r_op[r_cnt] ? (CoefExt << r_cnt) : '0);

  always_comb begin
    w_state_next      = r_state;
    w_acc_next        = r_acc;
    w_cnt_next        = r_cnt;
    w_op_next         = r_op;
    w_owner_next      = r_owner;
    w_ptr_next        = r_ptr;
    w_gnt_time_next   = 1'b0;
    w_gnt_pairs_next  = 1'b0;
    w_done_time_next  = 1'b0;
    w_done_pairs_next = 1'b0;
    w_res_time_next   = r_res_time;
    w_res_pairs_next  = r_res_pairs;
    if (flush) begin
      w_state_next     = StIdle;
      w_acc_next       = '0;
      w_cnt_next       = '0;
      w_ptr_next       = 1'b0;
      w_res_time_next  = '0;
      w_res_pairs_next = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_time || req_pairs) begin
            w_op_next        = w_pick_pairs ? op_pairs : op_time;
            w_acc_next       = '0;
            w_cnt_next       = '0;
            w_owner_next     = w_pick_pairs;
            w_gnt_time_next  = ~w_pick_pairs;
            w_gnt_pairs_next = w_pick_pairs;
            w_state_next     = StMul;
          end
        end
        StMul: begin
          w_acc_next = w_sum;
          if (r_cnt == LastBit) begin
            // Result and done are registered here so both are visible in the DONE cycle.
            if (r_owner) begin
              w_res_pairs_next  = w_sum;
              w_done_pairs_next = 1'b1;
            end else begin
              w_res_time_next  = w_sum;
              w_done_time_next = 1'b1;
            end
            w_state_next = StDone;
          end else begin
            w_cnt_next = r_cnt + CntW'(1);
          end
        end
        StDone: begin
          w_ptr_next   = ~r_owner;
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_op         <= '0;
      r_owner      <= 1'b0;
      r_ptr        <= 1'b0;
      r_gnt_time   <= 1'b0;
      r_gnt_pairs  <= 1'b0;
      r_done_time  <= 1'b0;
      r_done_pairs <= 1'b0;
      r_res_time   <= '0;
      r_res_pairs  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_acc        <= w_acc_next;
      r_cnt        <= w_cnt_next;
      r_op         <= w_op_next;
      r_owner      <= w_owner_next;
      r_ptr        <= w_ptr_next;
      r_gnt_time   <= w_gnt_time_next;
      r_gnt_pairs  <= w_gnt_pairs_next;
      r_done_time  <= w_done_time_next;
      r_done_pairs <= w_done_pairs_next;
      r_res_time   <= w_res_time_next;
      r_res_pairs  <= w_res_pairs_next;
    end
  end

  assign gnt_time                     = r_gnt_time;
  assign gnt_pairs                    = r_gnt_pairs;
  assign done_time                    = r_done_time;
  assign done_pairs                   = r_done_pairs;
  assign mult_time_result             = r_res_time;
  assign mult_discovered_pairs_result = r_res_pairs;
  assign busy                         = (r_state != StIdle);

endmodule

// File: tb/tb_score_mult_scheduler.sv
// Bench for score_mult_scheduler: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model (phase count, product by plain multiplication).
module tb_score_mult_scheduler;
  localparam int OPW  = 6;
  localparam int COEF = 100;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_time, req_pairs;
  logic [5:0]  op_time, op_pairs;
  logic        gnt_time, gnt_pairs, done_time, done_pairs, busy;
  logic [12:0] mult_time_result, mult_discovered_pairs_result;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 idle, 1..OPW multiplying, OPW+1 done.
  int m_phase, m_val;
  bit m_owner, m_ptr;
  int m_res[2];

  score_mult_scheduler dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .flush                        (flush),
    .req_time                     (req_time),
    .op_time                      (op_time),
    .req_pairs                    (req_pairs),
    .op_pairs                     (op_pairs),
    .gnt_time                     (gnt_time),
    .gnt_pairs                    (gnt_pairs),
    .done_time                    (done_time),
    .done_pairs                   (done_pairs),
    .mult_time_result             (mult_time_result),
    .mult_discovered_pairs_result (mult_discovered_pairs_result),
    .busy                         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_val    = 0;
    m_owner  = 1'b0;
    m_ptr    = 1'b0;
    m_res[0] = 0;
    m_res[1] = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_phase  = 0;
      m_ptr    = 1'b0;
      m_res[0] = 0;
      m_res[1] = 0;
    end else if (m_phase == 0) begin
      if (req_time || req_pairs) begin
        m_owner = req_pairs && (!req_time || m_ptr);
        m_val   = (m_owner ? int'(op_pairs) : int'(op_time)) * COEF;
        m_phase = 1;
      end
    end else if (m_phase < OPW) begin
      m_phase++;
    end else if (m_phase == OPW) begin
      m_phase          = OPW + 1;
      m_res[m_owner]   = m_val;
    end else begin
      m_ptr   = !m_owner;
      m_phase = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_gnt_time"},   int'(gnt_time),   int'(m_phase == 1 && !m_owner));
    check({tag, "_gnt_pairs"},  int'(gnt_pairs),  int'(m_phase == 1 && m_owner));
    check({tag, "_done_time"},  int'(done_time),  int'(m_phase == OPW + 1 && !m_owner));
    check({tag, "_done_pairs"}, int'(done_pairs), int'(m_phase == OPW + 1 && m_owner));
    check({tag, "_res_time"},   int'(mult_time_result), m_res[0]);
    check({tag, "_res_pairs"},  int'(mult_discovered_pairs_result), m_res[1]);
    check({tag, "_busy"},       int'(busy), int'(m_phase != 0));
  endtask

  // Drive one cycle's inputs (at negedge), advance one clock, compare at the next negedge.
  task automatic step(input bit ft, input bit rt, input int ot, input bit rp, input int op);
    flush     = ft;
    req_time  = rt;
    op_time   = 6'(ot);
    req_pairs = rp;
    op_pairs  = 6'(op);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic run(input int n, input bit ft, input bit rt, input int ot, input bit rp,
                     input int op);
    for (int i = 0; i < n; i++) step(ft, rt, ot, rp, op);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    flush = 1'b0; req_time = 1'b0; req_pairs = 1'b0; op_time = '0; op_pairs = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all("rst");
  endtask

  initial begin
    apply_reset();

    // Single request
    step(0, 1, 17, 0, 0);
    check("s1_gnt", int'(gnt_time), 1);
    run(6, 0, 1, 17, 0, 0);
    check("s1_done", int'(done_time), 1);
    check("s1_res", int'(mult_time_result), 1700);
    check("s1_pairs_res", int'(mult_discovered_pairs_result), 0);
    step(0, 0, 17, 0, 0);

    // Simultaneous requests after reset; time re-requests in cycle 8 and loses the tie
    apply_reset();
    run(7, 0, 1, 32, 1, 5);
    check("s2_done_time", int'(done_time), 1);
    check("s2_res_time", int'(mult_time_result), 3200);
    step(0, 0, 32, 1, 5);
    step(0, 1, 32, 1, 5);
    check("s2_gnt_pairs", int'(gnt_pairs), 1);
    check("s2_gnt_time_lo", int'(gnt_time), 0);
    run(6, 0, 1, 32, 1, 5);
    check("s2_done_pairs", int'(done_pairs), 1);
    check("s2_res_pairs", int'(mult_discovered_pairs_result), 500);
    run(2, 0, 1, 32, 0, 5);
    check("s2_gnt_time2", int'(gnt_time), 1);
    run(6, 0, 1, 32, 0, 5);
    check("s2_done_time2", int'(done_time), 1);
    step(0, 0, 0, 0, 0);

    // Operand extremes
    run(7, 0, 0, 0, 1, 0);
    check("s3_done_zero", int'(done_pairs), 1);
    check("s3_res_zero", int'(mult_discovered_pairs_result), 0);
    step(0, 0, 0, 0, 0);
    run(7, 0, 1, 63, 0, 0);
    check("s3_res_max", int'(mult_time_result), 6300);
    step(0, 0, 0, 0, 0);

    // Withdrawal and operand change after grant
    run(2, 0, 1, 40, 0, 0);
    step(0, 1, 1, 0, 0);
    run(4, 0, 0, 1, 0, 0);
    check("s4_done", int'(done_time), 1);
    check("s4_res", int'(mult_time_result), 4000);
    step(0, 0, 0, 0, 0);

    // Flush mid-multiply
    run(4, 0, 0, 0, 1, 9);
    check("s5_busy_mid", int'(busy), 1);
    step(1, 0, 0, 1, 9);
    check("s5_busy", int'(busy), 0);
    check("s5_no_done", int'(done_pairs), 0);
    check("s5_res_time", int'(mult_time_result), 0);
    step(0, 1, 7, 1, 9);
    check("s5_gnt_time", int'(gnt_time), 1);
    run(6, 0, 1, 7, 1, 9);
    check("s5_res", int'(mult_time_result), 700);
    step(0, 0, 0, 0, 0);

    // Asynchronous reset between edges, mid-multiply
    run(3, 0, 1, 17, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_busy", int'(busy), 0);
    check("s6_res", int'(mult_time_result), 0);
    model_reset();
    compare_all("arst");
    req_time = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(7, 0, 0, 0, 1, 3);
    check("s6_done", int'(done_pairs), 1);
    check("s6_res_pairs", int'(mult_discovered_pairs_result), 300);
    step(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, int'($urandom_range(0, 63)),
           $urandom_range(0, 2) != 0, int'($urandom_range(0, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
